// File: rtl/onchip_mem_avmm_ctl.sv
// Parametrised single-port on-chip RAM behind an Avalon-MM slave, with an optional post-reset clear sweep.
// Define ONCHIP_MEM_PARITY_EN for per-byte even parity storage and checking, and the parity_inject port.
module onchip_mem_avmm_ctl #(
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       ADDR_W         = 14,
  parameter int unsigned       READ_LATENCY   = 1,
  parameter int unsigned       CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE     = '0,
  parameter                    INIT_FILE      = "onchip_mem.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                reset_req,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
`ifdef ONCHIP_MEM_PARITY_EN
  input  logic                parity_inject,
`endif
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done,
  output logic                parity_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic {INIT, RUN} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? INIT : RUN;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ctr_q, ctr_d;
  logic                en, accept, rd_acc, wr_acc;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_be;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0]   s1_data_q, s1_data_d;
  logic                s1_err;

  assign en          = clken & ~reset_req;
  assign waitrequest = (state_q == INIT);
  assign init_done   = (state_q == RUN);
  assign accept      = chipselect & en & ~waitrequest;
  assign rd_acc      = accept & read & ~write;
  assign wr_acc      = accept & write;

  // The sweep borrows the single RAM port; bus commands are ignored until it finishes.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    mem_we    = wr_acc;
    mem_addr  = address;
    mem_wdata = writedata;
    mem_be    = byteenable;
    if (state_q == INIT) begin
      mem_we    = en;
      mem_addr  = ctr_q;
      mem_wdata = INIT_VALUE;
      mem_be    = '1;
      if (en) begin
        ctr_d = ctr_q + 1'b1;
        if (ctr_q == {ADDR_W{1'b1}}) state_d = RUN;
      end
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    if (en) begin
      s1_vld_d = rd_acc;
      if (rd_acc) s1_data_d = mem[address];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RESET_STATE;
      ctr_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

`ifdef ONCHIP_MEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] s1_par_q, s1_par_d;
  logic          inject;

  assign inject = (state_q == RUN) & parity_inject;

  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) par_mem[mem_addr][i] <= (^mem_wdata[8*i +: 8]) ^ inject;
      end
    end
  end

  always_comb begin
    s1_par_d = s1_par_q;
    if (en && rd_acc) s1_par_d = par_mem[address];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_par_q <= '0;
    else          s1_par_q <= s1_par_d;
  end

  always_comb begin
    s1_err = 1'b0;
    for (int i = 0; i < NB; i++) s1_err = s1_err | ((^s1_data_q[8*i +: 8]) ^ s1_par_q[i]);
  end
`else
  assign s1_err = 1'b0;
`endif

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              s2_vld_q, s2_vld_d, s2_err_q, s2_err_d;
      logic [DATA_W-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_vld_d  = s2_vld_q;
        s2_err_d  = s2_err_q;
        s2_data_d = s2_data_q;
        if (en) begin
          s2_vld_d = s1_vld_q;
          if (s1_vld_q) begin
            s2_data_d = s1_data_q;
            s2_err_d  = s1_err;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s2_vld_q  <= 1'b0;
          s2_err_q  <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_vld_q  <= s2_vld_d;
          s2_err_q  <= s2_err_d;
          s2_data_q <= s2_data_d;
        end
      end

      assign readdata      = s2_data_q;
      assign readdatavalid = s2_vld_q;
      assign parity_err    = s2_err_q;
    end else begin : g_lat1
      assign readdata      = s1_data_q;
      assign readdatavalid = s1_vld_q;
      assign parity_err    = s1_err;
    end
  endgenerate

endmodule

// File: tb/tb_onchip_mem_avmm_ctl.sv
// Directed self-checking bench for onchip_mem_avmm_ctl (ADDR_W=4, READ_LATENCY=2, clear sweep on).
module tb_onchip_mem_avmm_ctl;

  logic        clk;
  logic        reset_n;
  logic        clken;
  logic        reset_req;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [3:0]  address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        parity_inject;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        init_done;
  logic        parity_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];

  onchip_mem_avmm_ctl #(
    .DATA_W(32), .ADDR_W(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1),
    .INIT_VALUE(32'hA5A5A5A5), .INIT_FILE("onchip_mem.hex")
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .chipselect(chipselect), .read(read), .write(write), .address(address),
    .byteenable(byteenable), .writedata(writedata),
`ifdef ONCHIP_MEM_PARITY_EN
    .parity_inject(parity_inject),
`endif
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .init_done(init_done), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cs, input logic rd, input logic wr, input logic [3:0] addr,
                               input logic [3:0] be, input logic [31:0] wd, input logic inj);
    chipselect    = cs;
    read          = rd;
    write         = wr;
    address       = addr;
    byteenable    = be;
    writedata     = wd;
    parity_inject = inj;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
  endtask

  // Drives one write for a single cycle, then leaves the bus idle.
  task automatic doWrite(input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] be, input logic inj);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, be, wd, inj);
    @(posedge clk); #1;
    idle();
  endtask

  // Back-to-back reads; with latency 2 the read issued before edge i shows up after edge i+1.
  task automatic readBurst(input int first, input int count, input logic exp_perr, input string tag);
    for (int i = 0; i <= count + 1; i++) begin
      @(negedge clk);
      if (i < count) applyStimulus(1'b1, 1'b1, 1'b0, 4'(first + i), 4'h0, 32'h0, 1'b0);
      else           idle();
      @(posedge clk); #1;
      if (i >= 1 && i <= count) begin
        checkFlag($sformatf("%s_vld%0d", tag, i - 1), readdatavalid, 1'b1);
        checkOutput($sformatf("%s_data%0d", tag, i - 1), readdata, model[first + i - 1]);
        checkFlag($sformatf("%s_perr%0d", tag, i - 1), parity_err, exp_perr);
      end else begin
        checkFlag($sformatf("%s_novld%0d", tag, i), readdatavalid, 1'b0);
      end
    end
  endtask

  // Counts en-cycles until waitrequest drops; any readdatavalid seen meanwhile is an error.
  task automatic waitInit(input int exp_cycles, input string tag);
    int  n = 0;
    logic saw_vld = 1'b0;
    while (waitrequest === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (readdatavalid !== 1'b0) saw_vld = 1'b1;
    end
    idle();
    checkOutput({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    checkFlag({tag, "_done"}, init_done, 1'b1);
    checkFlag({tag, "_wait"}, waitrequest, 1'b0);
    checkFlag({tag, "_novld"}, saw_vld, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    clken     = 1'b1;
    reset_req = 1'b0;
    idle();
    for (int i = 0; i < 16; i++) model[i] = 32'hA5A5A5A5;

    #3;
    checkOutput("rst_readdata", readdata, 32'h0);
    checkFlag("rst_rdvalid", readdatavalid, 1'b0);
    checkFlag("rst_waitreq", waitrequest, 1'b1);
    checkFlag("rst_initdone", init_done, 1'b0);
    checkFlag("rst_perr", parity_err, 1'b0);

    $display("[TB] clear sweep after reset, bus write during sweep must be ignored");
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 32'h0000_0000, 1'b0);
    waitInit(16, "t1_sweep");
    readBurst(0, 16, 1'b0, "t1_rd");

    $display("[TB] partial byte write then read on the next cycle");
    doWrite(4'h3, 32'h11223344, 4'b0101, 1'b0);
    model[3] = 32'hA522A544;
    readBurst(3, 1, 1'b0, "t2_rd");

    $display("[TB] four consecutive reads return data in address order");
    doWrite(4'h0, 32'h01234567, 4'hF, 1'b0);
    doWrite(4'h1, 32'h89ABCDEF, 4'hF, 1'b0);
    doWrite(4'h2, 32'h77FFFFFF, 4'b1000, 1'b0);
    model[0] = 32'h01234567;
    model[1] = 32'h89ABCDEF;
    model[2] = 32'h77A5A5A5;
    readBurst(0, 4, 1'b0, "t3_rd");

    $display("[TB] simultaneous read and write: write wins, no read response");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'h5, 4'hF, 32'hDEADBEEF, 1'b0);
    @(posedge clk); #1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkFlag($sformatf("t4_novld%0d", i), readdatavalid, 1'b0);
    end
    model[5] = 32'hDEADBEEF;
    readBurst(5, 1, 1'b0, "t4_rd");

    $display("[TB] clken low for 3 cycles with a read in flight");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h3, 4'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    idle();
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkFlag($sformatf("t5_frozen%0d", i), readdatavalid, 1'b0);
    end
    clken = 1'b1;
    @(posedge clk); #1;
    checkFlag("t5_late_vld", readdatavalid, 1'b1);
    checkOutput("t5_late_data", readdata, model[3]);
    @(posedge clk); #1;
    checkFlag("t5_pulse_end", readdatavalid, 1'b0);

    $display("[TB] reset with a read in flight, then reset again mid-sweep");
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h5, 4'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    idle();
    #2 reset_n = 1'b0;
    #1;
    checkFlag("t5_rst_vld", readdatavalid, 1'b0);
    checkOutput("t5_rst_data", readdata, 32'h0);
    checkFlag("t5_rst_wait", waitrequest, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      checkFlag($sformatf("t5_sweepA%0d", i), readdatavalid, 1'b0);
    end
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    reset_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkFlag($sformatf("t5_pause_wait%0d", i), waitrequest, 1'b1);
    end
    reset_req = 1'b0;
    waitInit(12, "t5_sweepB");
    for (int i = 0; i < 16; i++) model[i] = 32'hA5A5A5A5;
    readBurst(0, 16, 1'b0, "t5_rd");

`ifdef ONCHIP_MEM_PARITY_EN
    $display("[TB] parity injection on one byte");
    doWrite(4'h2, 32'h000000FF, 4'b0001, 1'b1);
    model[2] = 32'hA5A5A5FF;
    readBurst(2, 1, 1'b1, "t6_bad");
    readBurst(3, 1, 1'b0, "t6_clean");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
